pipe_skid_slice: RTL
====================

Name: pipe_skid_slice

Overview:
- Consumer-side counterpart to the enable-gated pipeline register walls between processor stages.
- Converts enable/softReset-style stage registers into a registered valid/ready handshake, so a downstream stage can apply backpressure without a combinational ready path to the upstream stage.
- Two-entry skid buffer (main + skid register); full throughput, 1-cycle latency; sits between rename/dispatch and issue-queue write.

Parameters:
WIDTH, 6, payload width in bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset; state cleared on any rising clk edge where reset=0
softReset  input  1  synchronous active-high pipeline flush
enable  input  1  global stage enable; 0 freezes the slice
in_valid  input  1  upstream payload valid
in_data  input  WIDTH  upstream payload
in_ready  output  1  slice can accept payload this cycle
out_valid  output  1  payload presented downstream
out_data  output  WIDTH  downstream payload (main register)
out_ready  input  1  downstream accepts payload this cycle

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Internal state: main_q/main_v, skid_q/skid_v. States are EMPTY (no valid entries), ONE (main_v only) and FULL (main_v & skid_v). skid_v without main_v is illegal and never reached.
- Outputs:
  - out_valid = main_v & enable.
  - out_data = main_q.
  - in_ready = ~skid_v & enable. This is a registered-state function; there is no path from out_ready to in_ready.
- Priority per edge: reset=0 > softReset=1 > enable=0 (hold) > handshakes.
- Reset (reset=0): state EMPTY, main_q=0, skid_q=0. Outputs after the edge: out_valid=0, in_ready=enable, out_data=0.
- softReset=1: same clearing as reset, regardless of in_valid/out_ready that cycle. Payload presented in a flush cycle is dropped.
- enable=0: all registers hold; out_valid=0, in_ready=0, so no transfers occur.
- Transitions (enable=1):
  - EMPTY + in_fire -> ONE; main_q<=in_data.
  - ONE + in_fire & out_fire -> ONE; main_q<=in_data.
  - ONE + in_fire only -> FULL; skid_q<=in_data.
  - ONE + out_fire only -> EMPTY.
  - FULL + out_fire -> ONE; main_q<=skid_q, skid_v<=0 (in_ready=0 in FULL, so no input).
  - Otherwise hold.
- Latency: in_fire at edge N gives out_valid=1 with that payload after edge N (visible cycle N+1) when the slice was EMPTY.
- Throughput: 1 payload/cycle with out_ready held high.
- Ordering: strict FIFO; no drop or duplicate outside reset/flush.
- Stability: while out_valid=1 and out_ready=0, out_data is unchanged.
- Reset asserted mid-stream (any state): next cycle EMPTY. The payload accepted on that edge is lost.
- Simultaneous softReset and out_ready=1 in FULL: flush wins; both entries discarded; no out_fire is considered to have occurred for the pending entry beyond that cycle's observation.

Optional Feature:
Macro PIPE_SKID_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It increments on each edge where out_valid=1 and out_ready=0, saturates at 16'hFFFF, and clears on reset=0 or softReset=1. It holds when enable=0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then stream: reset=0 for 2 cycles, then in_valid=1 with data 6'h01..6'h05 on consecutive cycles, out_ready=1 -> out_data 01..05 on consecutive cycles, each one cycle after input; in_ready stays 1.
- Backpressure fill: out_ready=0, push 6'h0A then 6'h0B -> after second push in_ready=0 and out_data=0A held. Raise out_ready -> out 0A then 0B; in_ready returns to 1 the cycle after 0A drains.
- Flush in FULL: load 6'h11, 6'h22 with out_ready=0, assert softReset 1 cycle with in_valid=1 data 6'h33 -> next cycle out_valid=0, in_ready=1; 6'h33 never appears.
- Enable freeze: state ONE holding 6'h2A, enable=0 for 3 cycles with out_ready=1 and in_valid=1 -> out_valid=0, in_ready=0 throughout. After enable=1, out_data=2A is delivered exactly once.
- Reset mid-operation: FULL with 6'h15, 6'h16, drive reset=0 one edge -> out_valid=0, out_data=0, in_ready=1 next cycle.
- With PIPE_SKID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7; softReset -> 0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_skid_slice.sv
// -----------------------------------------------------------------------------
// pipe_skid_slice
//
// Purpose:
//   Two-entry skid buffer that places a registered valid/ready handshake
//   between rename/dispatch and the issue-queue write. It replaces an
//   enable/softReset-style stage register wall. Downstream backpressure
//   never reaches the upstream stage combinationally, because in_ready
//   depends only on registered state and enable. The slice gives full
//   throughput with 1-cycle latency.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (clears all state)
//   softReset  synchronous active-high pipeline flush (same clearing as reset)
//   enable     global stage enable; 0 freezes every register and blocks transfers
//   in_valid   upstream payload valid
//   in_data    upstream payload [WIDTH-1:0]
//   in_ready   slice can accept a payload this cycle
//   out_valid  payload presented downstream
//   out_data   downstream payload, always the main register
//   out_ready  downstream accepts the payload this cycle
//   stall_cnt  [15:0] saturating count of stalled cycles
//              (present only when PIPE_SKID_STALL_CNT_EN is defined)
//
// Optional feature:
//   Define PIPE_SKID_STALL_CNT_EN to add stall_cnt. On each edge where
//   out_valid=1 and out_ready=0, the counter adds 1 and saturates at
//   16'hFFFF. It is cleared by reset or softReset.
// -----------------------------------------------------------------------------
module pipe_skid_slice #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softReset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    input  logic             out_ready
);

    // EMPTY: no entries; ONE: main only; FULL: main and skid.
    // A skid entry without a main entry cannot be represented.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_fire;
    logic             out_fire;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]      stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first. Without these
        // defaults, a path that skips an assignment would infer a latch.
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;

        // Handshake signals depend only on state and enable.
        // out_ready never feeds in_ready.
        out_valid = (state_q != EMPTY) && enable;
        in_ready  = (state_q != FULL)  && enable;
        out_data  = main_q;
        in_fire   = in_valid  && in_ready;
        out_fire  = out_valid && out_ready;

        // When enable=0, both fires are 0, so the case below holds all state.
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d  = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is 0 here, so only a drain can happen.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A flush overrides any handshake this cycle and drops the presented payload.
        if (softReset) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        // out_valid already includes enable, so the count holds while frozen.
        if (softReset) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // NOTE: the payload registers are reset along with the state, so
    // out_data reads 0 right after reset rather than stale data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // All flops then sample the pre-edge values together.
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
